ring_rd_seqr: RTL and testbench

RING_RD_SEQR -- requirements
Module: ring_rd_seqr

---
 rtl/ring_rd_seqr.sv | 142 ++++++++++++++
 tb/tb_ring_rd_seqr.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ring_rd_seqr.sv
// Purpose: sequences ring-buffer reads for one event per L1A (smax samples x NSEQ words), with stall timeout abort.
// Latency: LOAD one cycle after a FIFO head is seen in IDLE; RD is combinational from the registered state; DONE follows the final RD by one cycle.
// Backpressure: RING_AMT or EVT_BUF_AFL withholds RD and parks in STALL; a stall run reaching TIMEOUT aborts the event with EVT_ERR.
module ring_rd_seqr #(
  parameter int NSEQ    = 96,
  parameter int TIMEOUT = 1023
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [6:0]  SAMP_MAX,
  input  logic        L1A_BUF_MT,
  input  logic        RING_AMT,
  input  logic        EVT_BUF_AFL,
  output logic        LD_ADDR,
  output logic        NXT_L1A,
  output logic        RD,
  output logic        EVT_DONE,
  output logic        EVT_ERR,
  output logic [2:0]  EVT_STATE,
  output logic [6:0]  SEQ,
  output logic [6:0]  SMP,
  output logic [15:0] EVT_CNT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_READ  = 3'd2,
    S_STALL = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [6:0]  SEQ_LAST = 7'(NSEQ - 1);
  localparam logic [15:0] STALL_TO = 16'(TIMEOUT);

  state_e      state_q, state_d;
  logic [6:0]  seq_q, seq_d;
  logic [6:0]  smp_q, smp_d;
  logic [6:0]  smax_q, smax_d;
  logic [15:0] stall_q, stall_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic        rd_ok;
  logic        rd_now;

  // Ring may be read only when it has data and downstream has room.
  assign rd_ok  = ~RING_AMT & ~EVT_BUF_AFL;
  assign rd_now = (state_q == S_READ) & rd_ok;

  // Next-state and counter update; illegal encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    smp_d   = smp_q;
    smax_d  = smax_q;
    stall_d = stall_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!L1A_BUF_MT && !EVT_BUF_AFL) state_d = S_LOAD;
      end
      S_LOAD: begin
        smax_d  = (SAMP_MAX == 7'd0) ? 7'd1 : SAMP_MAX;
        seq_d   = 7'd0;
        smp_d   = 7'd0;
        stall_d = 16'd0;
        err_d   = 1'b0;
        state_d = S_READ;
      end
      S_READ: begin
        if (rd_ok) begin
          stall_d = 16'd0;
          if (seq_q == SEQ_LAST) begin
            seq_d = 7'd0;
            if (smp_q == smax_q - 7'd1) begin
              // Final word of the event: leave indices at zero for the next one.
              smp_d   = 7'd0;
              state_d = S_DONE;
            end else begin
              smp_d = smp_q + 7'd1;
            end
          end else begin
            seq_d = seq_q + 7'd1;
          end
        end else begin
          state_d = S_STALL;
        end
      end
      S_STALL: begin
        stall_d = stall_q + 16'd1;
        if (stall_q + 16'd1 == STALL_TO) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (rd_ok) begin
          state_d = S_READ;
        end
      end
      S_DONE: begin
        cnt_d   = cnt_q + 16'd1;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      seq_q   <= 7'd0;
      smp_q   <= 7'd0;
      smax_q  <= 7'd1;
      stall_q <= 16'd0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      smp_q   <= smp_d;
      smax_q  <= smax_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode the registered state; RST masks them so a reset cycle never pops, loads or reads.
  assign LD_ADDR   = (state_q == S_LOAD) & ~RST;
  assign NXT_L1A   = (state_q == S_LOAD) & ~RST;
  assign RD        = rd_now & ~RST;
  assign EVT_DONE  = (state_q == S_DONE) & ~RST;
  assign EVT_ERR   = (state_q == S_DONE) & err_q & ~RST;
  assign EVT_STATE = state_q;
  assign SEQ       = seq_q;
  assign SMP       = smp_q;
  assign EVT_CNT   = cnt_q;

endmodule

// File: tb/tb_ring_rd_seqr.sv
// Directed bench for ring_rd_seqr with NSEQ=4, TIMEOUT=15.
// A small FIFO-level model and posedge monitors supply the environment; expectations are hand-computed.
module tb_ring_rd_seqr;

  logic        CLK = 1'b0;
  logic        RST;
  logic [6:0]  SAMP_MAX;
  logic        L1A_BUF_MT;
  logic        RING_AMT;
  logic        EVT_BUF_AFL;
  logic        LD_ADDR, NXT_L1A, RD, EVT_DONE, EVT_ERR;
  logic [2:0]  EVT_STATE;
  logic [6:0]  SEQ, SMP;
  logic [15:0] EVT_CNT;

  int total = 0;
  int bad   = 0;

  // Environment bookkeeping: each variable has a single writer.
  int pushed      = 0;
  int pop_cnt     = 0;
  int rd_cnt      = 0;
  int stall_cyc   = 0;
  int cyc         = 0;
  int last_rd_cyc = 0;
  int ld_cyc      = 0;
  int rd_base, st_base;

  always #5 CLK = ~CLK;

  assign L1A_BUF_MT = (pushed == pop_cnt);

  ring_rd_seqr #(.NSEQ(4), .TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST), .SAMP_MAX(SAMP_MAX), .L1A_BUF_MT(L1A_BUF_MT),
    .RING_AMT(RING_AMT), .EVT_BUF_AFL(EVT_BUF_AFL), .LD_ADDR(LD_ADDR),
    .NXT_L1A(NXT_L1A), .RD(RD), .EVT_DONE(EVT_DONE), .EVT_ERR(EVT_ERR),
    .EVT_STATE(EVT_STATE), .SEQ(SEQ), .SMP(SMP), .EVT_CNT(EVT_CNT)
  );

  always @(posedge CLK) begin
    cyc = cyc + 1;
    if (NXT_L1A === 1'b1 && pop_cnt < pushed) pop_cnt = pop_cnt + 1;
    if (RD === 1'b1) begin
      rd_cnt      = rd_cnt + 1;
      last_rd_cyc = cyc;
    end
    if (LD_ADDR === 1'b1) ld_cyc = cyc;
    if (EVT_STATE === 3'd3) stall_cyc = stall_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RST = 1'b1; SAMP_MAX = 7'd3; RING_AMT = 1'b0; EVT_BUF_AFL = 1'b0;
    step(); step();

    // Reset state
    chk("rst_state", EVT_STATE, 0);
    chk("rst_rd", RD, 0);
    chk("rst_ld", LD_ADDR, 0);
    chk("rst_pop", NXT_L1A, 0);
    chk("rst_done", EVT_DONE, 0);
    chk("rst_cnt", EVT_CNT, 0);
    chk("rst_seq", SEQ, 0);
    chk("rst_smp", SMP, 0);

    // Event 1: SAMP_MAX=3 -> 12 back-to-back reads
    rd_base = rd_cnt;
    RST = 1'b0; pushed = 1;
    step();
    chk("t1_load_state", EVT_STATE, 1);
    chk("t1_ld", LD_ADDR, 1);
    chk("t1_pop", NXT_L1A, 1);
    chk("t1_load_rd", RD, 0);
    step();
    for (int i = 0; i < 12; i++) begin
      chk("t1_rd", RD, 1);
      if (i == 6) begin
        chk("t1_seq_mid", SEQ, 2);
        chk("t1_smp_mid", SMP, 1);
      end
      step();
    end
    chk("t1_done", EVT_DONE, 1);
    chk("t1_err", EVT_ERR, 0);
    chk("t1_done_rd", RD, 0);
    chk("t1_fifo_popped", pop_cnt, 1);
    step();
    chk("t1_idle", EVT_STATE, 0);
    chk("t1_done_pulse", EVT_DONE, 0);
    chk("t1_cnt", EVT_CNT, 1);
    chk("t1_rd_total", rd_cnt - rd_base, 12);

    // Event 2: SAMP_MAX=0 treated as one sample
    rd_base = rd_cnt;
    SAMP_MAX = 7'd0; pushed = 2;
    step();
    chk("t2_load", EVT_STATE, 1);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t2_rd", RD, 1);
      chk("t2_smp", SMP, 0);
      step();
    end
    chk("t2_done", EVT_DONE, 1);
    chk("t2_smp_done", SMP, 0);
    step();
    chk("t2_rd_total", rd_cnt - rd_base, 4);
    chk("t2_cnt", EVT_CNT, 2);

    // Event 3: ring empty for 5 cycles after the 6th read
    rd_base = rd_cnt;
    SAMP_MAX = 7'd3; pushed = 3;
    step(); step();
    repeat (6) step();
    chk("t3_seq_before_stall", SEQ, 2);
    st_base = stall_cyc;
    RING_AMT = 1'b1;
    #1;
    chk("t3_rd_blocked", RD, 0);
    repeat (5) step();
    chk("t3_in_stall", EVT_STATE, 3);
    chk("t3_stall_rd", RD, 0);
    RING_AMT = 1'b0;
    step();
    chk("t3_stall_cycles", stall_cyc - st_base, 5);
    chk("t3_resume_state", EVT_STATE, 2);
    for (int i = 0; i < 6; i++) begin
      chk("t3_rd", RD, 1);
      step();
    end
    chk("t3_done", EVT_DONE, 1);
    chk("t3_err", EVT_ERR, 0);
    step();
    chk("t3_rd_total", rd_cnt - rd_base, 12);
    chk("t3_cnt", EVT_CNT, 3);

    // Event 4: ring stays empty after the 2nd read -> timeout abort
    rd_base = rd_cnt;
    pushed = 4;
    step(); step();
    repeat (2) step();
    st_base = stall_cyc;
    RING_AMT = 1'b1;
    for (int k = 0; k < 40 && EVT_DONE !== 1'b1; k++) step();
    chk("t4_done", EVT_DONE, 1);
    chk("t4_err", EVT_ERR, 1);
    chk("t4_stall_cycles", stall_cyc - st_base, 15);
    chk("t4_rd_total", rd_cnt - rd_base, 2);
    step();
    chk("t4_idle", EVT_STATE, 0);
    chk("t4_err_pulse", EVT_ERR, 0);
    chk("t4_cnt", EVT_CNT, 4);
    RING_AMT = 1'b0;

    // Event 5: reset mid-event with a second FIFO entry waiting
    pushed = 6;
    step(); step();
    repeat (6) step();
    chk("t5_seq", SEQ, 2);
    chk("t5_smp", SMP, 1);
    rd_base = rd_cnt;
    RST = 1'b1;
    #1;
    chk("t5_rst_rd", RD, 0);
    step();
    chk("t5_rst_state", EVT_STATE, 0);
    chk("t5_rst_seq", SEQ, 0);
    chk("t5_rst_smp", SMP, 0);
    chk("t5_rst_cnt", EVT_CNT, 0);
    chk("t5_rst_ld", LD_ADDR, 0);
    chk("t5_rst_pop", NXT_L1A, 0);
    chk("t5_rst_done", EVT_DONE, 0);
    chk("t5_rst_rd_total", rd_cnt - rd_base, 0);
    chk("t5_fifo_left", pushed - pop_cnt, 1);
    RST = 1'b0;
    step();
    chk("t5_load_after_rst", EVT_STATE, 1);
    chk("t5_ld_after_rst", LD_ADDR, 1);
    step();
    repeat (12) step();
    chk("t5_done", EVT_DONE, 1);
    step();
    chk("t5_cnt", EVT_CNT, 1);
    chk("t5_fifo_empty", pushed - pop_cnt, 0);

    // Event 6/7: two queued entries held off by almost-full, then back-to-back
    SAMP_MAX = 7'd0; EVT_BUF_AFL = 1'b1; pushed = 8;
    repeat (3) step();
    chk("t6_afl_idle", EVT_STATE, 0);
    chk("t6_afl_no_ld", LD_ADDR, 0);
    chk("t6_afl_no_pop", pushed - pop_cnt, 2);
    EVT_BUF_AFL = 1'b0;
    rd_base = rd_cnt;
    step();
    chk("t6_load1", EVT_STATE, 1);
    step();
    repeat (4) step();
    chk("t6_done1", EVT_DONE, 1);
    step();
    chk("t6_gap_idle", EVT_STATE, 0);
    step();
    chk("t6_load2", EVT_STATE, 1);
    step();
    chk("t6_gap", ld_cyc - last_rd_cyc, 3);
    repeat (4) step();
    chk("t6_done2", EVT_DONE, 1);
    step();
    chk("t6_cnt", EVT_CNT, 3);
    chk("t6_rd_total", rd_cnt - rd_base, 8);
    chk("t6_fifo_empty", pushed - pop_cnt, 0);
    step();
    chk("t6_stay_idle", EVT_STATE, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
